dac_transmision: RTL

- Serial transmitter for a 12-bit SPI-style DAC; the output-side counterpart of the ADC receive path.
- Takes a parallel sample plus a one-cycle start strobe from the sample-rate timer or the processing datapath.
- Drives a 16-bit MSB-first frame on DAC_data, framed by an active-low CS, clocked by SCLK.
- Has a one-deep holding register, so a sample that arrives during a frame is sent immediately after that frame.

---
 rtl/dac_transmision.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/dac_transmision.sv
// Serial transmitter for a 12-bit SPI-style DAC: 16-bit MSB-first frames under active-low CS,
// with a one-deep holding register so a sample arriving mid-frame goes out right after it.
module dac_transmision #(
    parameter int                        DATA_W      = 12,
    parameter int                        FRAME_W     = 16,
    parameter logic [FRAME_W-DATA_W-1:0] CTRL        = '0,
    parameter int                        CS_HIGH_MIN = 2
) (
    input  logic               SCLK,
    input  logic               reset,
    input  logic               tx_en,
    input  logic               start,
    input  logic [DATA_W-1:0]  data_in,
    output logic               CS,
    output logic               DAC_data,
    output logic               busy,
    output logic               tx_done_tick,
    output logic               overrun,
    output logic [FRAME_W-1:0] frame_reg
);
    localparam int CNT_W = $clog2(FRAME_W);
    localparam int GAP_W = 4;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   bit_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [FRAME_W-1:0] shift_reg;
    logic [DATA_W-1:0]  pend_data;
    logic               pending;
    logic [FRAME_W-1:0] frame_new;
    logic               bit_last;
    logic               gap_last;
    logic               load_new;
    logic               load_pend;
    logic               end_frame;
    logic               capture;
    logic               clr_pend;
    logic               ovr_set;

    assign bit_last  = (bit_cnt == CNT_W'(FRAME_W - 1));
    assign gap_last  = (gap_cnt == GAP_W'(CS_HIGH_MIN - 1));
    assign frame_new = load_pend ? {CTRL, pend_data} : {CTRL, data_in};
    assign busy      = (state != IDLE);

    always_ff @(posedge SCLK or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_new   = 1'b0;
        load_pend  = 1'b0;
        end_frame  = 1'b0;
        capture    = 1'b0;
        clr_pend   = 1'b0;
        ovr_set    = 1'b0;
        case (state)
            IDLE: begin
                if (start && tx_en) begin
                    state_next = SHIFT;
                    load_new   = 1'b1;
                end
            end
            SHIFT: begin
                if (bit_last) begin
                    state_next = GAP;
                    end_frame  = 1'b1;
                end
            end
            GAP: begin
                // A held sample takes priority; a fresh start on this edge then refills the holder.
                if (gap_last) begin
                    if (tx_en && pending) begin
                        state_next = SHIFT;
                        load_pend  = 1'b1;
                    end else if (tx_en && start) begin
                        state_next = SHIFT;
                        load_new   = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (!tx_en) begin
            clr_pend = 1'b1;
        end else if (start && (state != IDLE) && !load_new) begin
            capture = 1'b1;
            ovr_set = pending && !load_pend;
        end else if (load_pend) begin
            clr_pend = 1'b1;
        end
    end

    always_ff @(posedge SCLK or negedge reset) begin
        if (!reset) begin
            CS           <= 1'b1;
            DAC_data     <= 1'b0;
            tx_done_tick <= 1'b0;
            overrun      <= 1'b0;
            frame_reg    <= '0;
            pending      <= 1'b0;
            bit_cnt      <= '0;
            gap_cnt      <= '0;
        end else begin
            tx_done_tick <= end_frame;
            overrun      <= ovr_set;
            CS           <= (state_next != SHIFT);

            if (load_new || load_pend) begin
                DAC_data  <= frame_new[FRAME_W-1];
                frame_reg <= frame_new;
                bit_cnt   <= '0;
            end else if ((state == SHIFT) && !end_frame) begin
                DAC_data <= shift_reg[FRAME_W-2];
                bit_cnt  <= bit_cnt + 1'b1;
            end else begin
                DAC_data <= 1'b0;
            end

            if (end_frame) begin
                gap_cnt <= '0;
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt + 1'b1;
            end

            if (capture) begin
                pending <= 1'b1;
            end else if (clr_pend) begin
                pending <= 1'b0;
            end
        end
    end

    // Shift and holding data carry no reset; they are only observed once loaded.
    always_ff @(posedge SCLK) begin
        if (load_new || load_pend) begin
            shift_reg <= frame_new;
        end else if (state == SHIFT) begin
            shift_reg <= shift_reg << 1;
        end
        if (capture) begin
            pend_data <= data_in;
        end
    end

endmodule
